// File: rtl/rsa_stream_wrapper.sv
// Streams RSA operands from an Avalon-MM UART into an external exponentiation
// core and streams the result back out, one byte per polled transfer.
module rsa_stream_wrapper #(
  parameter int unsigned KEY_BITS  = 256,
  parameter int unsigned OUT_BYTES = KEY_BITS/8-1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  output logic [4:0]          avm_address,
  output logic                avm_read,
  output logic                avm_write,
  input  logic [31:0]         avm_readdata,
  output logic [31:0]         avm_writedata,
  input  logic                avm_waitrequest,
  input  logic                i_key_reload,
  output logic                o_core_start,
  output logic [KEY_BITS-1:0] o_core_n,
  output logic [KEY_BITS-1:0] o_core_e,
  output logic [KEY_BITS-1:0] o_core_a,
  input  logic [KEY_BITS-1:0] i_core_result,
  input  logic                i_core_finished,
  output logic [CNT_W-1:0]    o_block_cnt,
  output logic                o_key_valid
);

  localparam int unsigned KEY_BYTES = KEY_BITS/8;
  localparam int unsigned BC_W      = $clog2(KEY_BYTES) + 1;

  localparam logic [4:0] ADDR_RX     = 5'd0;
  localparam logic [4:0] ADDR_TX     = 5'd4;
  localparam logic [4:0] ADDR_STATUS = 5'd8;

  typedef enum logic [2:0] {POLL_RX, READ_RX, CALC, POLL_TX, WRITE_TX} state_t;
  typedef enum logic [1:0] {PH_N, PH_E, PH_A} phase_t;

  state_t              r_state, w_state_nxt;
  phase_t              r_phase;
  logic                r_req;
  logic [BC_W-1:0]     r_rx_cnt, r_tx_cnt;
  logic [KEY_BITS-1:0] r_n, r_e, r_a, r_result;
  logic                r_start, r_key_valid, r_reload_pend;
  logic [CNT_W-1:0]    r_block_cnt;

  logic       w_done, w_rx_last, w_tx_last;
  logic [7:0] w_rx_byte;
  logic       w_unused;

  assign w_done    = r_req & ~avm_waitrequest;
  assign w_rx_last = (r_rx_cnt == BC_W'(KEY_BYTES - 1));
  assign w_tx_last = (r_tx_cnt == BC_W'(OUT_BYTES - 1));
  assign w_rx_byte = avm_readdata[7:0];
  assign w_unused  = ^avm_readdata[31:8];

  assign o_core_start = r_start;
  assign o_core_n     = r_n;
  assign o_core_e     = r_e;
  assign o_core_a     = r_a;
  assign o_block_cnt  = r_block_cnt;
  assign o_key_valid  = r_key_valid;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) r_state <= POLL_RX;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      POLL_RX:  if (w_done && avm_readdata[7]) w_state_nxt = READ_RX;
      READ_RX:  if (w_done) w_state_nxt = (r_phase == PH_A && w_rx_last) ? CALC : POLL_RX;
      CALC:     if (i_core_finished) w_state_nxt = POLL_TX;
      POLL_TX:  if (w_done && avm_readdata[6]) w_state_nxt = WRITE_TX;
      WRITE_TX: if (w_done) w_state_nxt = w_tx_last ? POLL_RX : POLL_TX;
      default:  w_state_nxt = POLL_RX;
    endcase
  end

  // Bus signals decode from the held state and request flag, so they cannot
  // move while the slave stalls.
  always_comb begin
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = ADDR_STATUS;
    avm_writedata = '0;
    unique case (r_state)
      POLL_RX, POLL_TX: avm_read = r_req;
      READ_RX: begin
        avm_read    = r_req;
        avm_address = ADDR_RX;
      end
      WRITE_TX: begin
        avm_write     = r_req;
        avm_address   = ADDR_TX;
        avm_writedata = {24'd0, r_result[OUT_BYTES*8-1 -: 8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_req         <= 1'b1;
      r_phase       <= PH_N;
      r_rx_cnt      <= '0;
      r_tx_cnt      <= '0;
      r_n           <= '0;
      r_e           <= '0;
      r_a           <= '0;
      r_result      <= '0;
      r_start       <= 1'b0;
      r_key_valid   <= 1'b0;
      r_reload_pend <= 1'b0;
      r_block_cnt   <= '0;
    end else begin
      r_start <= 1'b0;
      // One idle cycle after every completed transfer; no requests during CALC.
      if (w_done)                         r_req <= 1'b0;
      else if (!r_req && r_state != CALC) r_req <= 1'b1;
      if (i_key_reload) r_reload_pend <= 1'b1;
      unique case (r_state)
        READ_RX: if (w_done) begin
          r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + 1'b1;
          unique case (r_phase)
            PH_N: begin
              r_n <= {r_n[KEY_BITS-9:0], w_rx_byte};
              if (w_rx_last) r_phase <= PH_E;
            end
            PH_E: begin
              r_e <= {r_e[KEY_BITS-9:0], w_rx_byte};
              if (w_rx_last) begin
                r_phase     <= PH_A;
                r_key_valid <= 1'b1;
              end
            end
            default: begin
              r_a <= {r_a[KEY_BITS-9:0], w_rx_byte};
              if (w_rx_last) r_start <= 1'b1;
            end
          endcase
        end
        CALC: if (i_core_finished) begin
          r_result <= i_core_result;
          r_tx_cnt <= '0;
        end
        WRITE_TX: if (w_done) begin
          r_result <= r_result << 8;
          r_tx_cnt <= r_tx_cnt + 1'b1;
          if (w_tx_last) begin
            r_block_cnt <= r_block_cnt + 1'b1;
            if (r_reload_pend) begin
              r_key_valid <= 1'b0;
              r_phase     <= PH_N;
            end
            // A reload arriving on this very cycle is kept for the next block.
            r_reload_pend <= i_key_reload;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
